// File: rtl/uart_tx_pkg.sv
// Shared types and defaults for the UART transmit arbiter slice.
package uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DONE,
    GAP
  } tx_state_e;

  localparam int unsigned FRAME_W            = 32;
  localparam int unsigned NUM_REQ_DEF        = 4;
  localparam int unsigned GAP_CYCLES_DEF     = 2;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 64;

  // Counter/index width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter handshake bundle of the UART transmit arbiter.
interface uart_tx_arbiter_if
  import uart_tx_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF
);
  logic [NUM_REQ-1:0]         req_i;
  logic [FRAME_W*NUM_REQ-1:0] req_data_i;
  logic [NUM_REQ-1:0]         grant_o;
  logic [NUM_REQ-1:0]         done_o;
  logic                       NewData;
  logic [FRAME_W-1:0]         DataIn;
  logic                       DoneTx;
  logic                       busy_o;
  logic                       timeout_o;

  modport master (
    output req_i, req_data_i, DoneTx,
    input  grant_o, done_o, NewData, DataIn, busy_o, timeout_o
  );

  modport slave (
    input  req_i, req_data_i, DoneTx,
    output grant_o, done_o, NewData, DataIn, busy_o, timeout_o
  );
endinterface

// File: rtl/uart_rr_arbiter.sv
// Pointer-based round-robin selector: lowest requester at or after ptr wins.
module uart_rr_arbiter
  import uart_tx_pkg::*;
#(
  parameter  int unsigned NUM_REQ = NUM_REQ_DEF,
  localparam int unsigned IDX_W   = cnt_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  always_comb begin
    int unsigned cand;
    logic        found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      // ptr is always below NUM_REQ, so one wrap subtraction suffices.
      cand = 32'(ptr) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && req[IDX_W'(cand)]) begin
        found     = 1'b1;
        grant     = NUM_REQ'(1) << cand;
        grant_idx = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one 32-bit UART transmitter among NUM_REQ requesters, round-robin.
// Optional DoneTx watchdog enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_tx_pkg::*;
#(
  parameter int unsigned NUM_REQ        = NUM_REQ_DEF,
  parameter int unsigned GAP_CYCLES     = GAP_CYCLES_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic             CLK_Baudin,
  input  logic             RstTx,
  uart_tx_arbiter_if.slave bus
);

  localparam int unsigned      IDX_W      = cnt_w(NUM_REQ);
  localparam int unsigned      GAP_W      = cnt_w(GAP_CYCLES);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_REQ - 1);
  localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam tx_state_e        AFTER_DONE = (GAP_CYCLES == 0) ? IDLE : GAP;

  tx_state_e          state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   rr_idx;
  logic [NUM_REQ-1:0] rr_gnt;
  logic [NUM_REQ-1:0] owner;
  logic [NUM_REQ-1:0] grant_r;
  logic [NUM_REQ-1:0] done_r;
  logic [FRAME_W-1:0] sel_data;
  logic [FRAME_W-1:0] data_r;
  logic               newdata_r;
  logic [GAP_W-1:0]   gap_cnt;

  uart_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req       (bus.req_i),
    .ptr       (ptr),
    .grant     (rr_gnt),
    .grant_idx (rr_idx)
  );

  assign sel_data = FRAME_W'(bus.req_data_i >> (FRAME_W * 32'(rr_idx)));

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int unsigned     TO_W    = cnt_w(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] wait_cnt;
  logic            timeout_r;

  assign bus.timeout_o = timeout_r;
`else
  assign bus.timeout_o = 1'b0;
`endif

  assign bus.grant_o = grant_r;
  assign bus.done_o  = done_r;
  assign bus.NewData = newdata_r;
  assign bus.DataIn  = data_r;
  assign bus.busy_o  = (state != IDLE);

  always_ff @(posedge CLK_Baudin) begin
    if (!RstTx) begin
      state     <= IDLE;
      ptr       <= '0;
      owner     <= '0;
      grant_r   <= '0;
      done_r    <= '0;
      newdata_r <= 1'b0;
      data_r    <= '0;
      gap_cnt   <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      wait_cnt  <= '0;
      timeout_r <= 1'b0;
`endif
    end else begin
      grant_r   <= '0;
      done_r    <= '0;
      newdata_r <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      timeout_r <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (|bus.req_i) begin
            grant_r <= rr_gnt;
            owner   <= rr_gnt;
            data_r  <= sel_data;
            ptr     <= (rr_idx == LAST_IDX) ? '0 : rr_idx + 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          newdata_r <= 1'b1;
`ifdef UART_TX_ARB_TIMEOUT_EN
          wait_cnt  <= '0;
`endif
          state     <= WAIT_DONE;
        end
        WAIT_DONE: begin
          // DoneTx is checked first so it wins over a same-cycle timeout.
          if (bus.DoneTx) begin
            done_r <= owner;
            state  <= AFTER_DONE;
          end
`ifdef UART_TX_ARB_TIMEOUT_EN
          else if (wait_cnt == TO_LAST) begin
            timeout_r <= 1'b1;
            state     <= AFTER_DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
            state   <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (NUM_REQ=4, GAP_CYCLES=2).
module tb_uart_tx_arbiter;
  import uart_tx_pkg::*;

  localparam int unsigned GAPC = 2;
  localparam int unsigned TOC  = 64;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  logic [31:0] words [4];

  uart_tx_arbiter_if #(.NUM_REQ(4)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ        (4),
    .GAP_CYCLES     (GAPC),
    .TIMEOUT_CYCLES (TOC)
  ) dut (
    .CLK_Baudin (clk),
    .RstTx      (rst_n),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_words();
    bus.req_data_i = {words[3], words[2], words[1], words[0]};
  endtask

  task automatic apply_reset();
    rst_n       = 1'b0;
    bus.req_i   = '0;
    bus.DoneTx  = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    bus.req_i      = 4'b1111;
    bus.DoneTx     = 1'b1;
    bus.req_data_i = {4{32'hFFFF_FFFF}};
    tick();
    tick();
    vectors++; if (bus.grant_o !== 4'b0000) begin miscompares++; $display("FAIL reset_grant: got %b expected 0000", bus.grant_o); end
    vectors++; if (bus.done_o !== 4'b0000) begin miscompares++; $display("FAIL reset_done: got %b expected 0000", bus.done_o); end
    vectors++; if (bus.NewData !== 1'b0) begin miscompares++; $display("FAIL reset_newdata: got %b expected 0", bus.NewData); end
    vectors++; if (bus.DataIn !== 32'h0) begin miscompares++; $display("FAIL reset_datain: got %h expected 00000000", bus.DataIn); end
    vectors++; if (bus.busy_o !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", bus.busy_o); end
    vectors++; if (bus.timeout_o !== 1'b0) begin miscompares++; $display("FAIL reset_timeout: got %b expected 0", bus.timeout_o); end
    bus.req_i  = '0;
    bus.DoneTx = 1'b0;
    rst_n      = 1'b1;
  endtask

  task automatic test_single();
    apply_reset();
    words = '{32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0};
    load_words();
    bus.req_i = 4'b0001;
    tick();
    vectors++; if (bus.grant_o !== 4'b0001) begin miscompares++; $display("FAIL single_grant: got %b expected 0001", bus.grant_o); end
    vectors++; if (bus.NewData !== 1'b0) begin miscompares++; $display("FAIL single_early_newdata: got %b expected 0", bus.NewData); end
    vectors++; if (bus.busy_o !== 1'b1) begin miscompares++; $display("FAIL single_busy: got %b expected 1", bus.busy_o); end
    bus.req_i = 4'b0000;
    tick();
    vectors++; if (bus.NewData !== 1'b1) begin miscompares++; $display("FAIL single_newdata: got %b expected 1", bus.NewData); end
    vectors++; if (bus.DataIn !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL single_datain: got %h expected deadbeef", bus.DataIn); end
    vectors++; if (bus.grant_o !== 4'b0000) begin miscompares++; $display("FAIL single_grant_pulse: got %b expected 0000", bus.grant_o); end
    tick();
    vectors++; if (bus.NewData !== 1'b0) begin miscompares++; $display("FAIL single_newdata_pulse: got %b expected 0", bus.NewData); end
    vectors++; if (bus.busy_o !== 1'b1) begin miscompares++; $display("FAIL single_wait_busy: got %b expected 1", bus.busy_o); end
    bus.DoneTx = 1'b1;
    tick();
    bus.DoneTx = 1'b0;
    vectors++; if (bus.done_o !== 4'b0001) begin miscompares++; $display("FAIL single_done: got %b expected 0001", bus.done_o); end
    tick();
    vectors++; if (bus.done_o !== 4'b0000) begin miscompares++; $display("FAIL single_done_pulse: got %b expected 0000", bus.done_o); end
    vectors++; if (bus.busy_o !== 1'b1) begin miscompares++; $display("FAIL single_gap_busy: got %b expected 1", bus.busy_o); end
    tick();
    vectors++; if (bus.busy_o !== 1'b0) begin miscompares++; $display("FAIL single_idle_busy: got %b expected 0", bus.busy_o); end
  endtask

  task automatic test_round_robin();
    int n;
    logic [3:0] exp_g;
    apply_reset();
    words = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 32'h4444_0003};
    load_words();
    bus.req_i = 4'b1111;
    n = 0;
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      do begin tick(); n++; end while (bus.grant_o === 4'b0000 && n < 20);
      vectors++; if (bus.grant_o !== exp_g) begin miscompares++; $display("FAIL rr_grant[%0d]: got %b expected %b", k, bus.grant_o, exp_g); end
      vectors++; if (n != ((k == 0) ? 1 : int'(GAPC) + 1)) begin miscompares++; $display("FAIL rr_spacing[%0d]: got %0d expected %0d", k, n, (k == 0) ? 1 : int'(GAPC) + 1); end
      if (k == 4) bus.req_i = 4'b0000;
      tick();
      vectors++; if (bus.DataIn !== words[k % 4]) begin miscompares++; $display("FAIL rr_datain[%0d]: got %h expected %h", k, bus.DataIn, words[k % 4]); end
      tick();
      bus.DoneTx = 1'b1;
      tick();
      bus.DoneTx = 1'b0;
      vectors++; if (bus.done_o !== exp_g) begin miscompares++; $display("FAIL rr_done[%0d]: got %b expected %b", k, bus.done_o, exp_g); end
      n = 0;
    end
    tick();
    tick();
    vectors++; if (bus.busy_o !== 1'b0) begin miscompares++; $display("FAIL rr_end_busy: got %b expected 0", bus.busy_o); end
  endtask

  task automatic test_hold_and_spurious();
    apply_reset();
    words = '{32'h0, 32'hA5A5_0001, 32'h0, 32'h0};
    load_words();
    bus.req_i = 4'b0010;
    tick();
    vectors++; if (bus.grant_o !== 4'b0010) begin miscompares++; $display("FAIL hold_grant: got %b expected 0010", bus.grant_o); end
    bus.req_i = 4'b0000;
    tick();
    words[1] = 32'h1234_5678;
    load_words();
    tick();
    tick();
    vectors++; if (bus.DataIn !== 32'hA5A5_0001) begin miscompares++; $display("FAIL hold_datain: got %h expected a5a50001", bus.DataIn); end
    bus.DoneTx = 1'b1;
    tick();
    bus.DoneTx = 1'b0;
    vectors++; if (bus.done_o !== 4'b0010) begin miscompares++; $display("FAIL hold_done: got %b expected 0010", bus.done_o); end
    tick();
    tick();
    bus.DoneTx = 1'b1;
    tick();
    tick();
    vectors++; if (bus.done_o !== 4'b0000) begin miscompares++; $display("FAIL spurious_done: got %b expected 0000", bus.done_o); end
    vectors++; if (bus.busy_o !== 1'b0) begin miscompares++; $display("FAIL spurious_busy: got %b expected 0", bus.busy_o); end
    vectors++; if (bus.DataIn !== 32'hA5A5_0001) begin miscompares++; $display("FAIL spurious_datain: got %h expected a5a50001", bus.DataIn); end
    bus.DoneTx = 1'b0;
  endtask

  task automatic test_back_to_back();
    int n;
    apply_reset();
    bus.req_i = 4'b0100;
    tick();
    vectors++; if (bus.grant_o !== 4'b0100) begin miscompares++; $display("FAIL b2b_grant0: got %b expected 0100", bus.grant_o); end
    bus.DoneTx = 1'b1;
    tick();
    bus.DoneTx = 1'b0;
    vectors++; if (bus.done_o !== 4'b0000) begin miscompares++; $display("FAIL b2b_issue_donetx: got %b expected 0000", bus.done_o); end
    tick();
    vectors++; if (bus.busy_o !== 1'b1) begin miscompares++; $display("FAIL b2b_still_waiting: got %b expected 1", bus.busy_o); end
    bus.DoneTx = 1'b1;
    tick();
    bus.DoneTx = 1'b0;
    vectors++; if (bus.done_o !== 4'b0100) begin miscompares++; $display("FAIL b2b_done: got %b expected 0100", bus.done_o); end
    n = 0;
    do begin tick(); n++; end while (bus.grant_o === 4'b0000 && n < 20);
    vectors++; if (bus.grant_o !== 4'b0100) begin miscompares++; $display("FAIL b2b_grant1: got %b expected 0100", bus.grant_o); end
    vectors++; if (n != int'(GAPC) + 1) begin miscompares++; $display("FAIL b2b_spacing: got %0d expected %0d", n, int'(GAPC) + 1); end
    bus.req_i = 4'b0000;
    apply_reset();
  endtask

  task automatic test_reset_mid_frame();
    apply_reset();
    bus.req_i = 4'b0010;
    tick();
    bus.req_i = 4'b0000;
    tick();
    tick();
    rst_n      = 1'b0;
    bus.req_i  = 4'b1111;
    tick();
    vectors++; if (bus.busy_o !== 1'b0) begin miscompares++; $display("FAIL midrst_busy: got %b expected 0", bus.busy_o); end
    vectors++; if (bus.DataIn !== 32'h0) begin miscompares++; $display("FAIL midrst_datain: got %h expected 00000000", bus.DataIn); end
    rst_n      = 1'b1;
    bus.DoneTx = 1'b1;
    tick();
    bus.DoneTx = 1'b0;
    vectors++; if (bus.done_o !== 4'b0000) begin miscompares++; $display("FAIL midrst_no_done: got %b expected 0000", bus.done_o); end
    vectors++; if (bus.grant_o !== 4'b0001) begin miscompares++; $display("FAIL midrst_ptr_zero: got %b expected 0001", bus.grant_o); end
    apply_reset();
  endtask

  task automatic test_timeout();
    logic seen;
    apply_reset();
    bus.req_i = 4'b0001;
    tick();
    bus.req_i = 4'b0000;
    tick();
`ifdef UART_TX_ARB_TIMEOUT_EN
    seen = 1'b0;
    for (int i = 0; i < int'(TOC) - 1; i++) begin tick(); seen = seen | bus.timeout_o; end
    vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL to_early: got %b expected 0", seen); end
    tick();
    vectors++; if (bus.timeout_o !== 1'b1) begin miscompares++; $display("FAIL to_pulse: got %b expected 1", bus.timeout_o); end
    vectors++; if (bus.done_o !== 4'b0000) begin miscompares++; $display("FAIL to_no_done: got %b expected 0000", bus.done_o); end
    tick();
    vectors++; if (bus.timeout_o !== 1'b0) begin miscompares++; $display("FAIL to_pulse_width: got %b expected 0", bus.timeout_o); end
    apply_reset();
    bus.req_i = 4'b0001;
    tick();
    bus.req_i = 4'b0000;
    tick();
    for (int i = 0; i < int'(TOC) - 1; i++) tick();
    bus.DoneTx = 1'b1;
    tick();
    bus.DoneTx = 1'b0;
    vectors++; if (bus.done_o !== 4'b0001) begin miscompares++; $display("FAIL to_edge_done: got %b expected 0001", bus.done_o); end
    vectors++; if (bus.timeout_o !== 1'b0) begin miscompares++; $display("FAIL to_edge_no_timeout: got %b expected 0", bus.timeout_o); end
`else
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin tick(); seen = seen | bus.timeout_o; end
    vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL noto_timeout: got %b expected 0", seen); end
    vectors++; if (bus.busy_o !== 1'b1) begin miscompares++; $display("FAIL noto_waiting: got %b expected 1", bus.busy_o); end
    bus.DoneTx = 1'b1;
    tick();
    bus.DoneTx = 1'b0;
    vectors++; if (bus.done_o !== 4'b0001) begin miscompares++; $display("FAIL noto_done: got %b expected 0001", bus.done_o); end
`endif
    apply_reset();
  endtask

  initial begin
    vectors        = 0;
    miscompares    = 0;
    rst_n          = 1'b0;
    bus.req_i      = '0;
    bus.req_data_i = '0;
    bus.DoneTx     = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_hold_and_spurious();
    test_back_to_back();
    test_reset_mid_frame();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of requesters sharing one 32-bit UART transmitter.
REQ-002 The block SHALL have parameter GAP_CYCLES, default 2, giving the idle cycles inserted between consecutive frames (0 allowed).
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 64, giving the DoneTx wait limit (used only with UART_TX_ARB_TIMEOUT_EN).
REQ-004 Port CLK_Baudin  in  1  baud-rate clock; the block has this single clock.
REQ-005 Port RstTx  in  1  reset, synchronous and active-low.
REQ-006 Port req_i  in  NUM_REQ  per-requester transmit request, level, held until granted.
REQ-007 Port req_data_i  in  32*NUM_REQ  per-requester 32-bit word; slice k is bits [32k+31:32k].
REQ-008 Port grant_o  out  NUM_REQ  one-hot, one-cycle pulse: word of that requester captured.
REQ-009 Port done_o  out  NUM_REQ  one-hot, one-cycle pulse: that requester's frame completed.
REQ-010 Port NewData  out  1  one-cycle start strobe to the UART transmitter.
REQ-011 Port DataIn  out  32  registered word presented to the transmitter.
REQ-012 Port DoneTx  in  1  frame-complete pulse from the transmitter.
REQ-013 Port busy_o  out  1  high in every state except IDLE.
REQ-014 Port timeout_o  out  1  one-cycle pulse on DoneTx timeout; constant 0 without the macro.

Function
REQ-015 FSM states SHALL be IDLE, ISSUE, WAIT_DONE and GAP.
REQ-016 In IDLE with any req_i bit high, the block SHALL select one requester round-robin starting from pointer ptr, load DataIn, pulse grant_o for that requester, and move to ISSUE on the same edge.
REQ-017 ptr SHALL become (granted index + 1) mod NUM_REQ on each grant; a lone requester SHALL be granted back-to-back.
REQ-018 In ISSUE, NewData SHALL be high for exactly that one cycle, followed by WAIT_DONE; latency is req_i high in IDLE -> grant_o the next cycle -> NewData the cycle after that.
REQ-019 In WAIT_DONE, DoneTx=1 SHALL pulse done_o for the owner and enter GAP, or IDLE when GAP_CYCLES=0.
REQ-020 GAP SHALL last exactly GAP_CYCLES cycles, then return to IDLE; requests SHALL be ignored in GAP.
REQ-021 DoneTx SHALL be ignored outside WAIT_DONE.
REQ-022 DataIn SHALL hold its value from grant until the next grant; changes on req_data_i after grant SHALL have no effect.
REQ-023 Deassertion of req_i after grant SHALL NOT abort the frame.

Reset
REQ-024 RstTx=0 at a rising edge SHALL force IDLE, ptr=0, counters=0, DataIn=0 and all outputs to 0, including mid-frame; no done_o is issued for an aborted frame.

Configuration
REQ-025 With UART_TX_ARB_TIMEOUT_EN defined, a WAIT_DONE cycle counter SHALL run, and reaching TIMEOUT_CYCLES without DoneTx SHALL pulse timeout_o, suppress done_o and enter GAP/IDLE.
REQ-026 DoneTx arriving in the same cycle the limit is reached SHALL take precedence, giving normal completion with no timeout.
REQ-027 Without the macro, no timeout counter SHALL exist, WAIT_DONE SHALL wait indefinitely, and timeout_o SHALL be tied 0.

Structure
REQ-028 Package uart_tx_pkg SHALL hold the FSM state enum, the frame-width constant (32), and the parameter defaults.
REQ-029 Sub-module uart_rr_arbiter SHALL implement pointer-based round-robin selection (request vector and ptr in, one-hot grant and index out).

Verification
REQ-030 Single request: req_i=0001, data 0xDEADBEEF -> grant_o=0001 at cycle 1, NewData at cycle 2 with DataIn=0xDEADBEEF; DoneTx -> done_o=0001.
REQ-031 All four requesting continuously -> grant order 0,1,2,3,0, with GAP_CYCLES idle cycles between each done_o and the next grant.
REQ-032 Change req_data_i during WAIT_DONE -> DataIn unchanged; spurious DoneTx in IDLE -> no done_o.
REQ-033 RstTx=0 during WAIT_DONE -> next cycle IDLE, outputs 0, ptr=0; next request is granted to index 0 first if pending.
REQ-034 Macro on, TIMEOUT_CYCLES=64, DoneTx withheld -> timeout_o pulse after 64 WAIT_DONE cycles, no done_o; DoneTx at cycle 64 -> done_o and no timeout.
